red_pitaya_guitar_octaver_mix: RTL and testbench

//  Parametrised octave-down effect for the guitar effect chain. Hysteretic signed zero-crossing

---
 rtl/red_pitaya_guitar_octaver_mix.sv | 134 +++++++++++++
 tb/tb_red_pitaya_guitar_octaver_mix.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_guitar_octaver_mix.sv
`default_nettype none
// ============================================================================
//  red_pitaya_guitar_octaver_mix
//  Octave-down effect: hysteretic crossing detector, 2-bit divider, peak
//  envelope follower, wet/dry mixer with saturation. Two-stage pipeline.
//  Revision: 1.0
// ============================================================================
module red_pitaya_guitar_octaver_mix #(
    parameter int DW       = 16,
    parameter int VW       = 16,
    parameter int HYST     = 16,
    parameter int DECAY_SH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 smp_en_i,
    input  logic signed [DW-1:0] in_sound_i,
    input  logic [1:0]           oct_sel_i,
    input  logic [VW-1:0]        dry_vol_i,
    input  logic [VW-1:0]        wet_vol_i,
    output logic signed [DW-1:0] out_sound_o,
    output logic                 out_valid_o,
    output logic                 edge_o
);

    typedef enum logic [0:0] {ST_NEG = 1'b0, ST_POS = 1'b1} state_t;

    localparam int PW = DW + VW + 2;
    localparam int MW = DW + VW + 1;
    localparam logic signed [DW-1:0] HYST_POS = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_NEG = DW'(-HYST);
    localparam logic signed [DW-1:0] S_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX  = {{(VW+2){1'b0}}, S_MAX};
    localparam logic signed [PW-1:0] SAT_MIN  = {{(VW+2){1'b1}}, S_MIN};

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  edge_q, edge_d;
    logic [DW-1:0]         env_q, env_d;
    logic [DW-1:0]         abs_d;
    logic                  sign_q, sign_d;
    logic signed [DW-1:0]  dry_s1_q;
    logic                  vld_s1_q;
    logic signed [DW-1:0]  out_q, out_d;
    logic                  out_valid_q;

    logic signed [DW-1:0]  wet_s;
    logic signed [MW-1:0]  prod_dry;
    logic signed [MW-1:0]  prod_wet;
    logic signed [PW-1:0]  sum;
    logic signed [PW-1:0]  shifted;

    // Stage 1: detector, divider, wet sign from post-update state, envelope
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = 1'b0;
        if (state_q == ST_NEG && in_sound_i >= HYST_POS) begin
            state_d = ST_POS;
            cnt_d   = cnt_q + 2'd1;
            edge_d  = 1'b1;
        end else if (state_q == ST_POS && in_sound_i <= HYST_NEG) begin
            state_d = ST_NEG;
        end

        case (oct_sel_i)
            2'd0:    sign_d = (state_d == ST_POS);
            2'd1:    sign_d = cnt_d[0];
            default: sign_d = cnt_d[1];
        endcase

        if (in_sound_i == S_MIN)
            abs_d = S_MAX;
        else if (in_sound_i[DW-1])
            abs_d = -in_sound_i;
        else
            abs_d = in_sound_i;

        if (abs_d > env_q)
            env_d = abs_d;
        else
            env_d = env_q - (env_q >> DECAY_SH);
    end

    // Stage 2: full-precision mix, arithmetic shift, clamp to DW
    always_comb begin
        wet_s    = sign_q ? $signed(env_q) : -$signed(env_q);
        prod_dry = MW'(dry_s1_q) * MW'($signed({1'b0, dry_vol_i}));
        prod_wet = MW'(wet_s)    * MW'($signed({1'b0, wet_vol_i}));
        sum      = {prod_dry[MW-1], prod_dry} + {prod_wet[MW-1], prod_wet};
        shifted  = sum >>> VW;
        if (shifted > SAT_MAX)
            out_d = S_MAX;
        else if (shifted < SAT_MIN)
            out_d = S_MIN;
        else
            out_d = shifted[DW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_NEG;
            cnt_q       <= 2'd0;
            edge_q      <= 1'b0;
            env_q       <= '0;
            sign_q      <= 1'b0;
            dry_s1_q    <= '0;
            vld_s1_q    <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            edge_q      <= 1'b0;
            vld_s1_q    <= smp_en_i;
            out_valid_q <= vld_s1_q;
            if (smp_en_i) begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                edge_q   <= edge_d;
                env_q    <= env_d;
                sign_q   <= sign_d;
                dry_s1_q <= in_sound_i;
            end
            if (vld_s1_q)
                out_q <= out_d;
        end
    end

    assign out_sound_o = out_q;
    assign out_valid_o = out_valid_q;
    assign edge_o      = edge_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_guitar_octaver_mix.sv
`default_nettype none
// ============================================================================
//  tb_red_pitaya_guitar_octaver_mix
//  Vector table plus scoreboarded reference model for the octaver mixer.
//  Revision: 1.0
// ============================================================================
module tb_red_pitaya_guitar_octaver_mix;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        smp_en_i = 1'b0;
    logic [15:0] in_sound_i = '0;
    logic [1:0]  oct_sel_i = '0;
    logic [15:0] dry_vol_i = '0;
    logic [15:0] wet_vol_i = '0;
    logic [15:0] out_sound_o;
    logic        out_valid_o;
    logic        edge_o;

    always #5 clk = ~clk;

    red_pitaya_guitar_octaver_mix #(
        .DW(16), .VW(16), .HYST(16), .DECAY_SH(10)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .smp_en_i   (smp_en_i),
        .in_sound_i (in_sound_i),
        .oct_sel_i  (oct_sel_i),
        .dry_vol_i  (dry_vol_i),
        .wet_vol_i  (wet_vol_i),
        .out_sound_o(out_sound_o),
        .out_valid_o(out_valid_o),
        .edge_o     (edge_o)
    );

    typedef struct {
        longint din;
        bit     sgn;
        longint env;
    } s1_t;

    typedef struct {
        longint din;
        longint dry;
        longint exp;
    } vec_t;

    s1_t    sb[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     m_state = 0;
    int     m_cnt = 0;
    longint m_env = 0;
    longint exp_out = 0;
    bit     exp_valid = 1'b0;
    bit     exp_edge = 1'b0;
    int     ph = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mix(input longint d, input bit s, input longint e,
                                   input longint dv, input longint wv);
        longint sum;
        longint q;
        sum = d * dv + (s ? e : -e) * wv;
        q   = sum >>> 16;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    // One clock: advance the reference model with the inputs seen at the edge,
    // then compare every output against it.
    task automatic tick();
        bit     r, s;
        longint din, a;
        int     osel;
        s1_t    rec;
        r    = rst_i;
        s    = smp_en_i;
        din  = $signed(in_sound_i);
        osel = int'(oct_sel_i);
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_edge  = 1'b0;
        if (r) begin
            sb.delete();
            exp_out = 0;
            m_state = 0;
            m_cnt   = 0;
            m_env   = 0;
        end else begin
            if (sb.size() > 0) begin
                rec       = sb.pop_front();
                exp_out   = mix(rec.din, rec.sgn, rec.env, longint'(dry_vol_i), longint'(wet_vol_i));
                exp_valid = 1'b1;
            end
            if (s) begin
                if (m_state == 0 && din >= 16) begin
                    m_state  = 1;
                    m_cnt    = (m_cnt + 1) % 4;
                    exp_edge = 1'b1;
                end else if (m_state == 1 && din <= -16) begin
                    m_state = 0;
                end
                a = (din < 0) ? -din : din;
                if (a > 32767) a = 32767;
                if (a > m_env) m_env = a;
                else           m_env = m_env - (m_env >> 10);
                rec.din = din;
                rec.env = m_env;
                rec.sgn = (osel == 0) ? (m_state == 1) :
                          (osel == 1) ? ((m_cnt & 1) != 0) : ((m_cnt & 2) != 0);
                sb.push_back(rec);
            end
        end
        chk("tick_valid", longint'(out_valid_o), longint'(exp_valid));
        chk("tick_out", $signed(out_sound_o), exp_out);
        chk("tick_edge", longint'(edge_o), longint'(exp_edge));
    endtask

    task automatic strobe(input longint d);
        in_sound_i = d[15:0];
        smp_en_i   = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        smp_en_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        smp_en_i = 1'b0;
        rst_i    = 1'b1;
        tick();
        tick();
        rst_i    = 1'b0;
    endtask

    function automatic longint sine_val(input int n);
        real x;
        x = 10000.0 * $sin(2.0 * 3.141592653589793 * real'(n) / 100.0);
        return longint'($floor(x + 0.5));
    endfunction

    task automatic run_sine(input int osel, input int nsmp, input int half, input int warm);
        int     last_edge, nchg, last_chg;
        bit     have_prev, prev_sg, sg;
        longint o, ao;
        last_edge = -1;
        nchg      = 0;
        last_chg  = 0;
        have_prev = 1'b0;
        prev_sg   = 1'b0;
        oct_sel_i = osel[1:0];
        for (int i = 0; i < nsmp; i++) begin
            strobe(sine_val(ph));
            ph++;
            if (edge_o) begin
                if (last_edge >= 0) chk("oct_edge_period", i - last_edge, 100);
                last_edge = i;
            end
            if (out_valid_o) begin
                o  = $signed(out_sound_o);
                ao = (o < 0) ? -o : o;
                sg = (o < 0);
                if (i >= warm) begin
                    chk("oct_amp_lo", longint'(ao >= 9000), 1);
                    chk("oct_amp_hi", longint'(ao <= 10000), 1);
                end
                if (have_prev && sg != prev_sg) begin
                    nchg++;
                    if (nchg >= 3 && i >= warm) chk("oct_half_period", i - last_chg, half);
                    last_chg = i;
                end
                prev_sg   = sg;
                have_prev = 1'b1;
            end
        end
    endtask

    vec_t   vecs[9];
    longint dexp[41];
    int     cnt_e, last_e, n_pos;
    longint e;

    initial begin
        vecs[0] = '{4096,   32768, 2048};
        vecs[1] = '{-4096,  32768, -2048};
        vecs[2] = '{32767,  65535, 32766};
        vecs[3] = '{-32768, 65535, -32768};
        vecs[4] = '{3,      1,     0};
        vecs[5] = '{-1,     1,     -1};
        vecs[6] = '{100,    0,     0};
        vecs[7] = '{-1000,  65535, -1000};
        vecs[8] = '{12345,  16384, 3086};

        // Reset with the strobe toggling: nothing may come out
        in_sound_i = 16'd1000;
        for (int i = 0; i < 5; i++) begin
            smp_en_i = i[0];
            tick();
            chk("rst_out", $signed(out_sound_o), 0);
            chk("rst_valid", longint'(out_valid_o), 0);
            chk("rst_edge", longint'(edge_o), 0);
        end
        rst_i = 1'b0;
        strobe(1000);
        chk("rst_first_edge", longint'(edge_o), 1);
        idle(3);

        // Dry-only vectors: latency exactly two edges, one-cycle valid, hold
        do_reset();
        wet_vol_i = 16'd0;
        oct_sel_i = 2'd0;
        foreach (vecs[k]) begin
            dry_vol_i = vecs[k].dry[15:0];
            strobe(vecs[k].din);
            smp_en_i = 1'b0;
            chk("vec_valid_early", longint'(out_valid_o), 0);
            tick();
            chk("vec_valid", longint'(out_valid_o), 1);
            chk("vec_out", $signed(out_sound_o), vecs[k].exp);
            tick();
            chk("vec_valid_late", longint'(out_valid_o), 0);
            chk("vec_out_hold", $signed(out_sound_o), vecs[k].exp);
        end

        // Octave divider on a sine, wet only
        do_reset();
        dry_vol_i = 16'd0;
        wet_vol_i = 16'hFFFF;
        ph = 0;
        run_sine(1, 500, 100, 150);
        run_sine(2, 900, 200, 0);
        run_sine(3, 900, 200, 0);
        idle(2);

        // Hysteresis: +/-10 never crosses, +/-20 crosses every second sample
        do_reset();
        oct_sel_i = 2'd0;
        cnt_e = 0;
        n_pos = 0;
        for (int i = 0; i < 20; i++) begin
            strobe(i[0] ? -10 : 10);
            if (edge_o) cnt_e++;
            if (out_valid_o && $signed(out_sound_o) > 0) n_pos++;
        end
        chk("hyst_small_edges", cnt_e, 0);
        chk("hyst_small_sign", n_pos, 0);
        cnt_e  = 0;
        last_e = -1;
        for (int i = 0; i < 20; i++) begin
            strobe(i[0] ? -20 : 20);
            if (edge_o) begin
                if (last_e >= 0) chk("hyst_edge_spacing", i - last_e, 2);
                last_e = i;
                cnt_e++;
            end
        end
        chk("hyst_big_edges", cnt_e, 10);
        idle(2);

        // Saturation at both rails
        do_reset();
        oct_sel_i = 2'd0;
        dry_vol_i = 16'hFFFF;
        wet_vol_i = 16'hFFFF;
        repeat (4) strobe(32767);
        idle(1);
        chk("sat_pos", $signed(out_sound_o), 32767);
        repeat (4) strobe(-32768);
        idle(1);
        chk("sat_neg", $signed(out_sound_o), -32768);

        // Envelope decay after a step, wet only
        do_reset();
        dry_vol_i = 16'd0;
        wet_vol_i = 16'hFFFF;
        e = 16384;
        for (int k = 0; k < 41; k++) begin
            if (k > 0) e = e - (e >> 10);
            dexp[k] = (e * 65535) >>> 16;
        end
        strobe(16384);
        for (int j = 1; j <= 40; j++) begin
            strobe(0);
            chk("decay_out", $signed(out_sound_o), dexp[j-1]);
        end
        idle(1);
        chk("decay_last", $signed(out_sound_o), dexp[40]);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
